// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the fetch stage: pc_src codes, FSM state encoding,
// default NOP/HALT words and a saturating increment used by the perf counters.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'b00,
        FETCH_RUN  = 2'b01,
        FETCH_HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction_mem read port plus the ID-side control and IF/ID outputs.
// Optional perf counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface instruction_fetch_if;

    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] inst_in;
    logic [31:0] inst_addr;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    // if_id_valid has no ready partner: ID back-pressures with stall, which
    // holds pc and every if_id_* field; valid=0 marks a bubble, not a word.
    modport master (
        input  stall, pc_src, branch_offset, jump_index, jr_target, inst_in,
        output inst_addr, if_id_pc4, if_id_inst, if_id_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , output perf_fetched, perf_bubbles
`endif
    );

    modport slave (
        output stall, pc_src, branch_offset, jump_index, jr_target, inst_in,
        input  inst_addr, if_id_pc4, if_id_inst, if_id_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , input perf_fetched, perf_bubbles
`endif
    );

endinterface

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC mux: sequential pc+4 or a redirect target based on the
// PC+4 of the instruction currently in ID (if_id_pc4).
module fetch_next_pc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic [1:0]  pc_src,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + PC_STEP;
        case (pc_src)
            PC_SRC_BRANCH: next_pc = if_id_pc4 + (branch_offset << 2);
            PC_SRC_JUMP:   next_pc = {if_id_pc4[31:28], jump_index, 2'b00};
            PC_SRC_JR:     next_pc = jr_target & ~32'h0000_0003;
            default:       next_pc = pc + PC_STEP;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction_mem and fills the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetched/bubble counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = HALT_WORD,
    parameter logic [31:0] NOP_INST  = NOP_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  bus,
    output fetch_state_e         state_dbg
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc4_q, pc4_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    logic [31:0]  next_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  fetched_q, fetched_d;
    logic [31:0]  bubbles_q, bubbles_d;
`endif

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .if_id_pc4     (pc4_q),
        .branch_offset (bus.branch_offset),
        .jump_index    (bus.jump_index),
        .jr_target     (bus.jr_target),
        .pc_src        (bus.pc_src),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        halted_d = halted_q;
`ifdef FETCH_PERF_CNT_EN
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
`endif
        case (state_q)
            // One dead cycle lets the memory's first read settle.
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN: begin
                if (!bus.stall) begin
                    pc_d = next_pc;
                    if (bus.pc_src != PC_SRC_SEQ) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                        bubbles_d = sat_inc(bubbles_q);
`endif
                    end else begin
                        pc4_d   = next_pc;
                        inst_d  = bus.inst_in;
                        valid_d = 1'b1;
`ifdef FETCH_PERF_CNT_EN
                        fetched_d = sat_inc(fetched_q);
`endif
                        if (bus.inst_in == HALT_INST) begin
                            halted_d = 1'b1;
                            state_d  = FETCH_HALT;
                        end
                    end
                end
            end
            FETCH_HALT: valid_d = 1'b0;
            default:    state_d = FETCH_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_BOOT;
            pc_q     <= RESET_PC;
            pc4_q    <= 32'h0000_0000;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetched_q <= 32'h0000_0000;
            bubbles_q <= 32'h0000_0000;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
`ifdef FETCH_PERF_CNT_EN
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
`endif
        end
    end

    assign bus.inst_addr   = pc_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_inst  = inst_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign state_dbg       = state_q;
`ifdef FETCH_PERF_CNT_EN
    assign bus.perf_fetched = fetched_q;
    assign bus.perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch (RESET_PC=0x40): directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_state_e state_dbg;
    instruction_fetch_if bus ();

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Instruction memory: sparse overrides, otherwise an address hash that can never be HALT.
    logic [31:0] imem [logic [31:0]];
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (imem.exists(a)) return imem[a];
        return ((a ^ 32'h5A5A_A5A4) & ~32'h0000_0002) | 32'h0000_0001;
    endfunction
    assign bus.inst_in = mem_read(bus.inst_addr);

    // Reference model: mode 0=boot, 1=running, 2=halted.
    int          m_mode;
    logic [31:0] m_pc, m_pc4, m_inst;
    logic        m_valid, m_halted;
    logic [31:0] m_fetched, m_bubbles;

    task automatic model_step();
        logic [31:0] w;
        if (rst) begin
            m_mode = 0; m_pc = RST_PC; m_pc4 = 0; m_inst = NOP_WORD;
            m_valid = 0; m_halted = 0; m_fetched = 0; m_bubbles = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_valid = 0;
        end else if (!bus.stall) begin
            if (bus.pc_src == 2'd0) begin
                w = mem_read(m_pc);
                m_pc = m_pc + 4; m_pc4 = m_pc; m_inst = w; m_valid = 1;
                if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
                if (w == HALT_WORD) begin m_halted = 1; m_mode = 2; end
            end else begin
                if (bus.pc_src == 2'd1)      m_pc = m_pc4 + bus.branch_offset * 4;
                else if (bus.pc_src == 2'd2) m_pc = {m_pc4[31:28], bus.jump_index, 2'b00};
                else                         m_pc = {bus.jr_target[31:2], 2'b00};
                m_inst = NOP_WORD; m_valid = 0;
                if (m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic [1:0] src,
                        input logic [31:0] off, input logic [25:0] idx, input logic [31:0] jr);
        rst = r; bus.stall = s; bus.pc_src = src;
        bus.branch_offset = off; bus.jump_index = idx; bus.jr_target = jr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 2'd0, 0, 0, 0);
        tick(1, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.inst_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.inst_addr, RST_PC); end
        checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== NOP_WORD || bus.if_id_pc4 !== 32'h0)
            begin errors++; $display("FAIL reset_ifid got %b/%h/%h exp 0/%h/0", bus.if_id_valid, bus.if_id_inst, bus.if_id_pc4, NOP_WORD); end
        checks++; if (bus.halted !== 1'b0 || state_dbg !== FETCH_BOOT) begin errors++; $display("FAIL reset_state got %b/%0d exp 0/BOOT", bus.halted, state_dbg); end
    endtask

    task automatic test_boot_seq();
        logic [31:0] exp_addr [3] = '{32'h40, 32'h44, 32'h48};
        logic        exp_vld  [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 2'd0, 0, 0, 0);
            checks++; if (bus.inst_addr !== exp_addr[i] || bus.if_id_valid !== exp_vld[i])
                begin errors++; $display("FAIL boot_seq%0d got %h/%b exp %h/%b", i, bus.inst_addr, bus.if_id_valid, exp_addr[i], exp_vld[i]); end
        end
        checks++; if (bus.if_id_inst !== mem_read(32'h44) || bus.if_id_pc4 !== 32'h48)
            begin errors++; $display("FAIL boot_capture got %h/%h exp %h/48", bus.if_id_inst, bus.if_id_pc4, mem_read(32'h44)); end
    endtask

    task automatic test_branch();
        tick(0, 0, 2'd3, 0, 0, 32'h103);
        tick(0, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.if_id_pc4 !== 32'h104) begin errors++; $display("FAIL branch_setup got %h exp 104", bus.if_id_pc4); end
        tick(0, 0, 2'd1, 32'hFFFF_FFFE, 0, 0);
        checks++; if (bus.inst_addr !== 32'hFC) begin errors++; $display("FAIL branch_pc got %h exp fc", bus.inst_addr); end
        checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_inst !== NOP_WORD)
            begin errors++; $display("FAIL branch_squash got %b/%h exp 0/%h", bus.if_id_valid, bus.if_id_inst, NOP_WORD); end
    endtask

    task automatic test_jump_jr();
        tick(0, 0, 2'd3, 0, 0, 32'h1000_0004);
        tick(0, 0, 2'd0, 0, 0, 0);
        tick(0, 0, 2'd2, 0, 26'h000_0010, 0);
        checks++; if (bus.inst_addr !== 32'h1000_0040) begin errors++; $display("FAIL jump_pc got %h exp 10000040", bus.inst_addr); end
        tick(0, 0, 2'd3, 0, 0, 32'h203);
        checks++; if (bus.inst_addr !== 32'h200) begin errors++; $display("FAIL jr_pc got %h exp 200", bus.inst_addr); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, pc40;
        tick(0, 0, 2'd0, 0, 0, 0);
        pc0 = m_pc; pc40 = m_pc4;
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 2'd1, 32'd4, 0, 0);
            checks++; if (bus.inst_addr !== pc0 || bus.if_id_pc4 !== pc40 || bus.if_id_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold%0d got %h/%h/%b exp %h/%h/1", i, bus.inst_addr, bus.if_id_pc4, bus.if_id_valid, pc0, pc40); end
        end
        tick(0, 0, 2'd1, 32'd4, 0, 0);
        checks++; if (bus.inst_addr !== pc40 + 32'd16 || bus.if_id_valid !== 1'b0)
            begin errors++; $display("FAIL stall_release got %h/%b exp %h/0", bus.inst_addr, bus.if_id_valid, pc40 + 32'd16); end
    endtask

    task automatic test_wrap();
        tick(0, 0, 2'd3, 0, 0, 32'hFFFF_FFFC);
        tick(0, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.inst_addr !== 32'h0 || bus.if_id_pc4 !== 32'h0)
            begin errors++; $display("FAIL wrap got %h/%h exp 0/0", bus.inst_addr, bus.if_id_pc4); end
    endtask

    task automatic test_halt();
        imem[32'h8] = HALT_WORD;
        tick(1, 0, 2'd0, 0, 0, 0);
        tick(0, 0, 2'd0, 0, 0, 0);
        tick(0, 0, 2'd3, 0, 0, 32'h0);
        tick(0, 0, 2'd0, 0, 0, 0);
        tick(0, 0, 2'd0, 0, 0, 0);
        tick(0, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.halted !== 1'b1 || bus.if_id_valid !== 1'b1 || bus.if_id_inst !== HALT_WORD || bus.inst_addr !== 32'hC)
            begin errors++; $display("FAIL halt_capture got %b/%b/%h/%h exp 1/1/%h/c", bus.halted, bus.if_id_valid, bus.if_id_inst, bus.inst_addr, HALT_WORD); end
        for (int i = 0; i < 3; i++) tick(0, 0, 2'($urandom_range(0, 3)), $urandom, 26'($urandom), $urandom);
        checks++; if (bus.inst_addr !== 32'hC || bus.if_id_valid !== 1'b0 || bus.halted !== 1'b1 || state_dbg !== FETCH_HALT)
            begin errors++; $display("FAIL halt_frozen got %h/%b/%b exp c/0/1", bus.inst_addr, bus.if_id_valid, bus.halted); end
        tick(1, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.inst_addr !== RST_PC || bus.halted !== 1'b0 || state_dbg !== FETCH_BOOT)
            begin errors++; $display("FAIL halt_reset got %h/%b exp %h/0", bus.inst_addr, bus.halted, RST_PC); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        tick(1, 0, 2'd0, 0, 0, 0);
        checks++; if (bus.perf_fetched !== 32'h0 || bus.perf_bubbles !== 32'h0)
            begin errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", bus.perf_fetched, bus.perf_bubbles); end
        tick(0, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 2'd0, 0, 0, 0);
        tick(0, 1, 2'd1, 32'd8, 0, 0);
        tick(0, 0, 2'd1, 32'd8, 0, 0);
        checks++; if (bus.perf_fetched !== 32'd5 || bus.perf_bubbles !== 32'd1)
            begin errors++; $display("FAIL perf_count got %0d/%0d exp 5/1", bus.perf_fetched, bus.perf_bubbles); end
    endtask
`endif

    task automatic test_random();
        tick(1, 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            src = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, src,
                 32'($urandom_range(0, 63)) - 32'd32, 26'($urandom), $urandom);
            checks++; if (bus.inst_addr !== m_pc || bus.if_id_pc4 !== m_pc4 || bus.if_id_inst !== m_inst ||
                          bus.if_id_valid !== m_valid || bus.halted !== m_halted)
                begin errors++; $display("FAIL random%0d got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", i,
                    bus.inst_addr, bus.if_id_pc4, bus.if_id_inst, bus.if_id_valid, bus.halted,
                    m_pc, m_pc4, m_inst, m_valid, m_halted); end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (bus.perf_fetched !== m_fetched || bus.perf_bubbles !== m_bubbles)
                begin errors++; $display("FAIL random_perf%0d got %0d/%0d exp %0d/%0d", i,
                    bus.perf_fetched, bus.perf_bubbles, m_fetched, m_bubbles); end
`endif
        end
    endtask

    initial begin
        bus.stall = 0; bus.pc_src = 0; bus.branch_offset = 0; bus.jump_index = 0; bus.jr_target = 0;
        test_reset();
        test_boot_seq();
        test_branch();
        test_jump_jr();
        test_stall();
        test_wrap();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
